cam_capture_ctrl: RTL

- Sequences camera-to-frame-buffer writes on the write port of the dual-port buffer RAM.
- Samples the OV7670-style parallel bus (PCLK, VSYNC, HREF, D[7:0]) in the system clock domain and packs RGB565 byte pairs into RGB332 pixels.
- Generates the write address and write strobe, clipping the frame to CAM_SCREEN_X × CAM_SCREEN_Y.
- Offers a start/busy/done handshake for single-shot or continuous capture under SoC control.

---
 rtl/cam_pkg.sv | 27 ++
 rtl/cam_sync_in.sv | 49 ++++
 rtl/cam_capture_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// Shared types and constants for the camera capture path: screen geometry
// defaults, state encoding and the RGB565 -> RGB332 packing rule.
package cam_pkg;

    localparam int CAM_SCREEN_X_DEF = 160;
    localparam int CAM_SCREEN_Y_DEF = 120;
    localparam int AW_DEF           = 15;
    localparam int DW_DEF           = 8;

    localparam logic [7:0] RGB332_BLACK = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_SYNC,
        ST_HI,
        ST_LO,
        ST_WRBG,
        ST_DONE
    } cam_state_e;

    // Keep the top bits of each colour field: R[4:2], G[5:3], B[4:3].
    function automatic logic [7:0] rgb565_to_332(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[7:5], hi[2:0], lo[4:3]};
    endfunction

endpackage

// File: rtl/cam_sync_in.sv
// Brings the asynchronous camera bus into the system clock domain and
// flags each rising edge of the camera pixel clock.
module cam_sync_in (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       pclk_i,
    input  logic       vsync_i,
    input  logic       href_i,
    input  logic [7:0] data_i,
    output logic       pclk_rise_o,
    output logic       vsync_o,
    output logic       href_o,
    output logic [7:0] data_o
);

    logic [1:0] pclk_q;
    logic [1:0] vsync_q;
    logic [1:0] href_q;
    logic       pclk_prev_q;
    logic [7:0] data0_q, data1_q, data2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pclk_q      <= '0;
            vsync_q     <= '0;
            href_q      <= '0;
            pclk_prev_q <= 1'b0;
            data0_q     <= '0;
            data1_q     <= '0;
            data2_q     <= '0;
        end else begin
            pclk_q      <= {pclk_q[0], pclk_i};
            vsync_q     <= {vsync_q[0], vsync_i};
            href_q      <= {href_q[0], href_i};
            pclk_prev_q <= pclk_q[1];
            // One stage deeper than the control path so the byte seen on
            // pclk_rise was launched well before that camera edge.
            data0_q     <= data_i;
            data1_q     <= data0_q;
            data2_q     <= data1_q;
        end
    end

    assign pclk_rise_o = pclk_q[1] & ~pclk_prev_q;
    assign vsync_o     = vsync_q[1];
    assign href_o      = href_q[1];
    assign data_o      = data2_q;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Camera-to-frame-buffer write sequencer: packs byte pairs into RGB332 pixels,
// clips to the screen window and closes each frame with one background write.
module cam_capture_ctrl
    import cam_pkg::*;
#(
    parameter int               CAM_SCREEN_X = CAM_SCREEN_X_DEF,
    parameter int               CAM_SCREEN_Y = CAM_SCREEN_Y_DEF,
    parameter int               AW           = AW_DEF,
    parameter int               DW           = DW_DEF,
    parameter logic [DW-1:0]    BG_COLOR     = DW'(RGB332_BLACK)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cam_pclk,
    input  logic          cam_vsync,
    input  logic          cam_href,
    input  logic [7:0]    cam_data,
    input  logic          cap_start,
    input  logic          cap_continuous,
    output logic          cap_busy,
    output logic          cap_done,
    output logic [7:0]    frame_cnt,
    output logic          err_odd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_we,
    output cam_state_e    dbg_state_o
);

    localparam int            CW         = $clog2(CAM_SCREEN_X + 1);
    localparam int            RW         = $clog2(CAM_SCREEN_Y + 1);
    localparam logic [CW-1:0] COL_MAX    = CW'(CAM_SCREEN_X);
    localparam logic [RW-1:0] ROW_MAX    = RW'(CAM_SCREEN_Y);
    localparam logic [AW-1:0] ROW_STRIDE = AW'(CAM_SCREEN_X);
    localparam logic [AW-1:0] BG_ADDR    = AW'(CAM_SCREEN_X * CAM_SCREEN_Y);

    logic       pclk_rise, vsync_s, href_s;
    logic [7:0] data_s;

    cam_sync_in u_sync (
        .clk_i       (clk),
        .rst_ni      (rst),
        .pclk_i      (cam_pclk),
        .vsync_i     (cam_vsync),
        .href_i      (cam_href),
        .data_i      (cam_data),
        .pclk_rise_o (pclk_rise),
        .vsync_o     (vsync_s),
        .href_o      (href_s),
        .data_o      (data_s)
    );

    cam_state_e    state_q;
    logic          vsync_prev_q, href_prev_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [AW-1:0] pix_idx_q, line_base_q;
    logic          line_pix_q;
    logic [7:0]    hi_q;
    logic          busy_q, done_q, err_odd_q, mem_we_q;
    logic [7:0]    frame_cnt_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_data_q;

    logic vsync_rise, vsync_fall, href_fall, in_window;
    assign vsync_rise = vsync_s & ~vsync_prev_q;
    assign vsync_fall = ~vsync_s & vsync_prev_q;
    assign href_fall  = ~href_s & href_prev_q;
    assign in_window  = (col_q < COL_MAX) && (row_q < ROW_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            vsync_prev_q <= 1'b0;
            href_prev_q  <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            pix_idx_q    <= '0;
            line_base_q  <= '0;
            line_pix_q   <= 1'b0;
            hi_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_odd_q    <= 1'b0;
            frame_cnt_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            vsync_prev_q <= vsync_s;
            href_prev_q  <= href_s;
            mem_we_q     <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cap_start) begin
                        state_q   <= ST_ARM;
                        busy_q    <= 1'b1;
                        err_odd_q <= 1'b0;
                    end
                end
                ST_ARM: begin
                    if (vsync_s) state_q <= ST_SYNC;
                end
                ST_SYNC: begin
                    if (vsync_fall) begin
                        state_q     <= ST_HI;
                        col_q       <= '0;
                        row_q       <= '0;
                        pix_idx_q   <= '0;
                        line_base_q <= '0;
                        line_pix_q  <= 1'b0;
                    end
                end
                ST_HI, ST_LO: begin
                    // Frame end wins over a coincident line end.
                    if (vsync_rise) begin
                        state_q <= ST_WRBG;
                    end else if (href_fall) begin
                        if (state_q == ST_LO) err_odd_q <= 1'b1;
                        state_q    <= ST_HI;
                        col_q      <= '0;
                        line_pix_q <= 1'b0;
                        if (line_pix_q && row_q < ROW_MAX) begin
                            row_q       <= row_q + RW'(1);
                            line_base_q <= line_base_q + ROW_STRIDE;
                            pix_idx_q   <= line_base_q + ROW_STRIDE;
                        end else begin
                            pix_idx_q   <= line_base_q;
                        end
                    end else if (pclk_rise && href_s) begin
                        if (state_q == ST_HI) begin
                            hi_q    <= data_s;
                            state_q <= ST_LO;
                        end else begin
                            state_q    <= ST_HI;
                            line_pix_q <= 1'b1;
                            if (in_window) begin
                                mem_we_q   <= 1'b1;
                                mem_addr_q <= pix_idx_q;
                                mem_data_q <= DW'(rgb565_to_332(hi_q, data_s));
                                pix_idx_q  <= pix_idx_q + AW'(1);
                            end
                            if (col_q < COL_MAX) col_q <= col_q + CW'(1);
                        end
                    end
                end
                ST_WRBG: begin
                    mem_we_q   <= 1'b1;
                    mem_addr_q <= BG_ADDR;
                    mem_data_q <= BG_COLOR;
                    state_q    <= ST_DONE;
                end
                ST_DONE: begin
                    done_q      <= 1'b1;
                    frame_cnt_q <= frame_cnt_q + 8'd1;
                    if (cap_continuous) begin
                        state_q <= ST_ARM;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cap_busy    = busy_q;
    assign cap_done    = done_q;
    assign frame_cnt   = frame_cnt_q;
    assign err_odd     = err_odd_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data    = mem_data_q;
    assign mem_we      = mem_we_q;
    assign dbg_state_o = state_q;

endmodule
